// File: rtl/alu_mdu.sv
// alu_mdu: single-issue integer ALU with an iterative multiply/divide unit.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready is high only in IDLE)
//   funct3_CONTROL      operation select
//   funct7_bit_CONTROL  alternate op for the base group (SUB, SRA)
//   m_ext               1 = multiply/divide group, 0 = base group
//   op_a, op_b          XLEN-bit operands, captured on accept
//   out_valid/out_ready result handshake
//   op_out              registered result, held until the result handshake
//   busy                high while iterating a multiply or divide
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3_CONTROL,
  input  logic            funct7_bit_CONTROL,
  input  logic            m_ext,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_out,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic              accept_s, last_s;
  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic              div_zero_s, div_ovf_s, special_s;
  logic [SHW-1:0]    shamt_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, base_res_s, special_res_s;

  // Iteration state: acc_r holds {remainder, quotient} for divide and
  // {product high, multiplier/product low} for multiply; opnd_r holds the
  // divisor or the multiplicand magnitude.
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opnd_r;
  logic [SHW-1:0]    cnt_r;
  logic [2:0]        f3_r;
  logic              neg_r, a_neg_r;

  logic [XLEN:0]     mul_sum_s, div_shift_s, div_trial_s;
  logic              div_ge_s;
  logic [2*XLEN-1:0] mul_nxt_s, div_nxt_s, prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, mul_res_s, div_res_s;

  assign accept_s = in_valid && (state_r == IDLE);
  assign last_s   = (cnt_r == SHW'(XLEN-1));

  // Operand decode: signedness, magnitudes and the single-cycle divide cases.
  always_comb begin
    shamt_s = op_b[SHW-1:0];
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (funct3_CONTROL)
      3'b001, 3'b100, 3'b110: begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b1;
      end
      3'b010:  a_sgn_s = 1'b1;
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
    a_neg_s = a_sgn_s & op_a[XLEN-1];
    b_neg_s = b_sgn_s & op_b[XLEN-1];
    mag_a_s = a_neg_s ? (ZERO - op_a) : op_a;
    mag_b_s = b_neg_s ? (ZERO - op_b) : op_b;
    div_zero_s = funct3_CONTROL[2] && (op_b == ZERO);
    // Overflow only exists for the signed forms (DIV=100, REM=110).
    div_ovf_s  = funct3_CONTROL[2] && !funct3_CONTROL[0] &&
                 (op_a == MOST_NEG) && (op_b == ALL_ONES);
    special_s  = m_ext && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      special_res_s = funct3_CONTROL[1] ? op_a : ALL_ONES;
    end else begin
      special_res_s = funct3_CONTROL[1] ? ZERO : op_a;
    end
  end

  // Base-group result, computed straight from the request inputs.
  always_comb begin
    base_res_s = ZERO;
    case (funct3_CONTROL)
      3'b000:  base_res_s = funct7_bit_CONTROL ? (op_a - op_b) : (op_a + op_b);
      3'b001:  base_res_s = op_a << shamt_s;
      3'b010:  base_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011:  base_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100:  base_res_s = op_a ^ op_b;
      3'b101:  base_res_s = funct7_bit_CONTROL ? XLEN'($signed(op_a) >>> shamt_s)
                                               : (op_a >> shamt_s);
      3'b110:  base_res_s = op_a | op_b;
      3'b111:  base_res_s = op_a & op_b;
      default: base_res_s = ZERO;
    endcase
  end

  // One shift-add / restoring-subtract step plus the final sign fixups.
  always_comb begin
    mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                  (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    mul_nxt_s   = {mul_sum_s, acc_r[XLEN-1:1]};
    div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    div_trial_s = div_shift_s - {1'b0, opnd_r};
    // Shifted remainder is always < 2*divisor, so bit XLEN is a clean borrow.
    div_ge_s    = ~div_trial_s[XLEN];
    div_nxt_s   = {(div_ge_s ? div_trial_s[XLEN-1:0] : div_shift_s[XLEN-1:0]),
                   acc_r[XLEN-2:0], div_ge_s};
    prod_fix_s  = neg_r ? ({(2*XLEN){1'b0}} - mul_nxt_s) : mul_nxt_s;
    mul_res_s   = (f3_r[1:0] == 2'b00) ? prod_fix_s[XLEN-1:0]
                                       : prod_fix_s[2*XLEN-1:XLEN];
    quo_fix_s   = neg_r ? (ZERO - div_nxt_s[XLEN-1:0]) : div_nxt_s[XLEN-1:0];
    rem_fix_s   = a_neg_r ? (ZERO - div_nxt_s[2*XLEN-1:XLEN])
                          : div_nxt_s[2*XLEN-1:XLEN];
    div_res_s   = f3_r[1] ? rem_fix_s : quo_fix_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (!m_ext || special_s) begin
            state_s = DONE;
          end else begin
            state_s = funct3_CONTROL[2] ? DIV : MUL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
      busy      <= (state_s == MUL) || (state_s == DIV);
    end
  end

  // Datapath: capture on accept, iterate, write the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_out  <= ZERO;
      acc_r   <= {(2*XLEN){1'b0}};
      opnd_r  <= ZERO;
      cnt_r   <= {SHW{1'b0}};
      f3_r    <= 3'b000;
      neg_r   <= 1'b0;
      a_neg_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            f3_r    <= funct3_CONTROL;
            neg_r   <= a_neg_s ^ b_neg_s;
            a_neg_r <= a_neg_s;
            cnt_r   <= {SHW{1'b0}};
            if (!m_ext) begin
              op_out <= base_res_s;
            end else if (special_s) begin
              op_out <= special_res_s;
            end else begin
              acc_r  <= {ZERO, (funct3_CONTROL[2] ? mag_a_s : mag_b_s)};
              opnd_r <= funct3_CONTROL[2] ? mag_b_s : mag_a_s;
            end
          end
        end
        MUL: begin
          acc_r <= mul_nxt_s;
          cnt_r <= cnt_r + SHW'(1);
          if (last_s) begin
            op_out <= mul_res_s;
          end
        end
        DIV: begin
          acc_r <= div_nxt_s;
          cnt_r <= cnt_r + SHW'(1);
          if (last_s) begin
            op_out <= div_res_s;
          end
        end
        default: begin
          op_out <= op_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32): directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3_CONTROL = 3'b000;
  logic        funct7_bit_CONTROL = 1'b0;
  logic        m_ext = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] op_out;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .funct3_CONTROL(funct3_CONTROL), .funct7_bit_CONTROL(funct7_bit_CONTROL),
    .m_ext(m_ext), .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
    .out_ready(out_ready), .op_out(op_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic m, input logic [2:0] f3,
                                            input logic f7, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    longint unsigned pu;
    logic [63:0] p;
    logic [31:0] r;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = 32'd0;
    if (!m) begin
      case (f3)
        3'd0: r = f7 ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else begin
      case (f3)
        3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
        3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
        3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
        3'd3: begin pu = 64'(ua) * 64'(ub); p = pu; r = p[63:32]; end
        3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
        3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
        3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_latency(input logic m, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
    if (!m) return 1;
    if (f3[2] && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one request, wait for the result, optionally stall the consumer
  // while presenting a competing request, then complete the handshake.
  task automatic do_op(input string tag, input logic m, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input int stall);
    logic [31:0] exp;
    int exp_lat;
    int lat;
    exp = ref_model(m, f3, f7, a, b);
    exp_lat = ref_latency(m, f3, a, b);
    check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; m_ext = m; funct3_CONTROL = f3; funct7_bit_CONTROL = f7;
    op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom; op_b = $urandom; funct3_CONTROL = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({tag, ":busy"}, 64'(busy), 64'd1);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ":result"}, 64'(op_out), 64'(exp));
    check({tag, ":busy_done"}, 64'(busy), 64'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1; op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
      check({tag, ":hold"}, 64'(op_out), 64'(exp));
      check({tag, ":hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, ":hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, ":valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, ":idle"}, 64'(in_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset, with a request presented that must not be taken.
    in_valid = 1'b1; op_a = 32'd3; op_b = 32'd4;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst:out_valid", 64'(out_valid), 64'd0);
    check("rst:busy", 64'(busy), 64'd0);
    check("rst:op_out", 64'(op_out), 64'd0);
    check("rst:in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("rst:no_accept", 64'(out_valid), 64'd0);

    // Directed cases.
    do_op("add",    1'b0, 3'd0, 1'b0, 32'd5, 32'd7, 0);
    do_op("sub",    1'b0, 3'd0, 1'b1, 32'd3, 32'd5, 0);
    do_op("mulh",   1'b1, 3'd1, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("mulhu",  1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("mul",    1'b1, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
    do_op("div",    1'b1, 3'd4, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("rem",    1'b1, 3'd6, 1'b0, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("divu0",  1'b1, 3'd5, 1'b0, 32'h0000_1234, 32'd0, 0);
    do_op("remu0",  1'b1, 3'd7, 1'b0, 32'h0000_1234, 32'd0, 0);
    do_op("divovf", 1'b1, 3'd4, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("removf", 1'b1, 3'd6, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("sra",    1'b0, 3'd5, 1'b1, 32'h8000_0000, 32'h0000_0024, 0);
    do_op("sltu",   1'b0, 3'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 0);
    do_op("slt",    1'b0, 3'd2, 1'b0, 32'd1, 32'hFFFF_FFFF, 0);
    do_op("stall",  1'b0, 3'd4, 1'b0, 32'hA5A5_0F0F, 32'h0FF0_1234, 5);

    // Reset in the middle of a divide discards it.
    in_valid = 1'b1; m_ext = 1'b1; funct3_CONTROL = 3'd4;
    op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("middiv:busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("middiv:out_valid", 64'(out_valid), 64'd0);
    check("middiv:busy", 64'(busy), 64'd0);
    check("middiv:op_out", 64'(op_out), 64'd0);
    check("middiv:in_ready", 64'(in_ready), 64'd1);
    do_op("add_after_rst", 1'b0, 3'd0, 1'b0, 32'd1, 32'd1, 0);

    // Randomized operations.
    for (int k = 0; k < 200; k++) begin
      do_op("rand", 1'($urandom), 3'($urandom), 1'($urandom),
            pick_operand(), pick_operand(), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter: XLEN, 32, datapath width; SHALL be 32 or 64.
REQ-002 Parameter: SHW, $clog2(XLEN), shift-amount width; SHALL be derived, not overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 funct3_CONTROL  input  3  operation select.
REQ-008 funct7_bit_CONTROL  input  1  alternate op (SUB, SRA/SRAI).
REQ-009 m_ext  input  1  1 selects the multiply/divide group; 0 selects the base group.
REQ-010 op_a, op_b  input  XLEN each  operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 op_out  output  XLEN  registered result.
REQ-014 busy  output  1  high in MUL or DIV state.

Function
REQ-015 FSM states SHALL be IDLE, MUL, DIV, DONE; in_ready SHALL equal (state==IDLE).
REQ-016 Accept SHALL occur when in_valid && in_ready; operands and controls SHALL be captured on accept. Inputs SHALL be ignored otherwise.
REQ-017 Base group (m_ext=0): 000 ADD/SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND. Shifts SHALL use op_b[SHW-1:0]. Compares SHALL yield 1 or 0.
REQ-018 Base ops: IDLE->DONE on accept; out_valid SHALL assert on the cycle after accept (latency 1).
REQ-019 M group (m_ext=1): 000 MUL (low XLEN), 001 MULH (s*s), 010 MULHSU (s*u), 011 MULHU (u*u), 100 DIV, 101 DIVU, 110 REM, 111 REMU. funct7_bit_CONTROL SHALL be ignored.
REQ-020 Multiply SHALL be iterative shift-add, one bit per cycle on magnitudes with sign fixup of the 2*XLEN product. IDLE->MUL->DONE; out_valid SHALL assert exactly XLEN+1 cycles after accept.
REQ-021 Divide SHALL be iterative restoring, one quotient bit per cycle on magnitudes. Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). IDLE->DIV->DONE; out_valid SHALL assert XLEN+1 cycles after accept.
REQ-022 Divisor zero: quotient SHALL be all ones; remainder SHALL be op_a. The FSM SHALL go IDLE->DONE (latency 1).
REQ-023 Signed overflow (DIV/REM, op_a = most negative, op_b = -1): quotient SHALL be op_a; remainder SHALL be 0; latency 1.
REQ-024 DONE: out_valid=1; op_out SHALL be held stable until out_valid && out_ready. On that handshake the FSM SHALL go DONE->IDLE and out_valid SHALL deassert the next cycle.
REQ-025 Back-to-back requests: a new accept SHALL NOT occur in the same cycle as the output handshake. Minimum issue interval SHALL be 2 cycles for base ops.
REQ-026 busy SHALL be 1 exactly in MUL and DIV; out_valid SHALL be 0 in IDLE, MUL and DIV.
REQ-027 All arithmetic SHALL wrap modulo 2^XLEN. No exceptions or flags SHALL be produced.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE with out_valid=0, op_out=0, busy=0 and in_ready=1 the following cycle. This SHALL apply in any state, including mid-MUL/DIV; the pending result SHALL be discarded.
REQ-029 A request presented while rst=1 SHALL NOT be accepted.

Verification (XLEN=32)
REQ-030 ADD 5+7 then SUB 3-5 with out_ready=1 -> op_out=0x0000000C, then 0xFFFFFFFE; each out_valid 1 cycle after accept.
REQ-031 op_a=0xFFFFFFFF, op_b=2: MULH -> 0xFFFFFFFF; MULHU -> 0x00000001; MUL -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x00001234 at latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, each at latency 1.
REQ-033 SRA 0x80000000 by op_b=0x24 -> 0xF8000000 (amount 4); SLTU 1<0xFFFFFFFF -> 1; SLT 1<0xFFFFFFFF -> 0.
REQ-034 Result held with out_ready=0 for 5 cycles, in_valid=1 with new operands -> op_out stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle.
REQ-035 rst pulsed 10 cycles into a DIV -> next cycle out_valid=0, busy=0, op_out=0, in_ready=1; a following ADD 1+1 -> 0x00000002 at latency 1.
